// File: rtl/host_mem_byte_reader.sv
// Avalon-MM read initiator: fetches 32-bit words from host memory and unpacks them
// little-endian into a byte-wide valid/ready stream of a commanded length.
module host_mem_byte_reader #(
    parameter int ADDR_W       = 13,
    parameter int DEPTH_WORDS  = 7168,
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  byte_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic              avm_clken,
    input  logic [31:0]       avm_readdata,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic [31:0]       word;
    logic [1:0]        idx;
    logic [LAT_W-1:0]  lat_cnt;
    logic              lat_done;
    logic              accept;
    logic              last_byte;
    logic [ADDR_W-1:0] addr_next;

    assign lat_done  = (lat_cnt == LAT_W'(READ_LATENCY - 1));
    assign accept    = (state == ST_EMIT) && out_ready;
    assign last_byte = (remaining == CNT_W'(1));
    // Word addresses wrap at the memory depth, not at the port width
    assign addr_next = (addr == ADDR_W'(DEPTH_WORDS - 1)) ? '0 : addr + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (byte_count == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ:  state_next = ST_WAIT;
            ST_WAIT: begin
                if (lat_done) begin
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (accept) begin
                    if (last_byte) begin
                        state_next = ST_DONE;
                    end else if (idx == 2'd3) begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (abort && (state != ST_IDLE)) begin
            state_next = ST_IDLE;
        end
    end

    // Datapath updates are harmless on abort since the FSM returns to IDLE regardless
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr      <= '0;
            remaining <= '0;
            word      <= '0;
            idx       <= '0;
            lat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && (byte_count != '0)) begin
                        addr      <= start_addr;
                        remaining <= byte_count;
                    end
                end
                ST_REQ: lat_cnt <= '0;
                ST_WAIT: begin
                    if (lat_done) begin
                        word <= avm_readdata;
                        idx  <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (accept) begin
                        remaining <= remaining - 1'b1;
                        idx       <= idx + 2'd1;
                        if (!last_byte && (idx == 2'd3)) begin
                            addr <= addr_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_data = word[7:0];
        case (idx)
            2'd0: out_data = word[7:0];
            2'd1: out_data = word[15:8];
            2'd2: out_data = word[23:16];
            2'd3: out_data = word[31:24];
            default: out_data = word[7:0];
        endcase
    end

    assign busy           = (state != ST_IDLE);
    assign done           = (state == ST_DONE);
    assign out_valid      = (state == ST_EMIT);
    assign avm_chipselect = (state == ST_REQ);
    assign avm_address    = addr;
    assign avm_write      = 1'b0;
    assign avm_byteenable = 4'hF;
    assign avm_clken      = 1'b1;

endmodule

// File: tb/tb_host_mem_byte_reader.sv
// Scoreboard bench for host_mem_byte_reader: a behavioural memory answers reads and
// every accepted stream byte is checked against bytes predicted when each command is issued.
module tb_host_mem_byte_reader;

    localparam int ADDR_W       = 13;
    localparam int DEPTH_WORDS  = 7168;
    localparam int READ_LATENCY = 1;
    localparam int CNT_W        = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [CNT_W-1:0]  byte_count;
    logic              abort;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic              avm_clken;
    logic [31:0]       avm_readdata;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [7:0]        exp_q[$];
    logic [ADDR_W-1:0] cs_addr_q[$];
    int                n_compared   = 0;
    int                n_mismatched = 0;
    int                cyc          = 0;
    int                cs_cnt       = 0;
    int                done_cnt     = 0;
    int                valid_cnt    = 0;
    int                done_cyc     = 0;
    int                start_cyc    = 0;
    bit                rand_mode    = 1'b0;
    bit                stalled_prev = 1'b0;
    logic [7:0]        prev_data    = 8'h00;

    host_mem_byte_reader #(
        .ADDR_W      (ADDR_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .READ_LATENCY(READ_LATENCY),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .start_addr    (start_addr),
        .byte_count    (byte_count),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write     (avm_write),
        .avm_byteenable(avm_byteenable),
        .avm_clken     (avm_clken),
        .avm_readdata  (avm_readdata),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory with one cycle of read latency
    always @(posedge clk) begin
        if (avm_chipselect) begin
            avm_readdata <= mem[avm_address];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Output monitor sampled on the falling edge
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            valid_cnt++;
            if (stalled_prev) begin
                checkOutput("stall_stable", 32'(out_data), 32'(prev_data));
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_byte", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("byte", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
            stalled_prev = !out_ready;
            prev_data    = out_data;
        end else begin
            stalled_prev = 1'b0;
        end
        if (reset_n && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (reset_n && avm_chipselect) begin
            cs_cnt++;
            cs_addr_q.push_back(avm_address);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic applyStimulus(input int addr, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            logic [31:0] w;
            w = mem[(addr + i / 4) % DEPTH_WORDS];
            exp_q.push_back(8'(w >> (8 * (i % 4))));
        end
        start_addr = ADDR_W'(addr);
        byte_count = CNT_W'(cnt);
        start      = 1'b1;
        start_cyc  = cyc;
        tick();
        start      = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int base;
        bit seen;
        base = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done_cnt > base) seen = 1'b1;
        end
        if (!seen) checkOutput(tag, 32'd0, 32'd1);
    endtask

    initial begin
        int cs_base;
        int done_base;
        int valid_base;
        bit hit;

        reset_n    = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        byte_count = '0;
        abort      = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = $urandom;
        mem[16]   = 32'h4433_2211;
        mem[17]   = 32'h8877_6655;
        mem[7167] = 32'hDDCC_BBAA;
        mem[0]    = 32'h0403_0201;

        tick();
        tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_cs", 32'(avm_chipselect), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_addr", 32'(avm_address), 32'd0);
        checkOutput("rst_data", 32'(out_data), 32'd0);
        checkOutput("const_write", 32'(avm_write), 32'd0);
        checkOutput("const_be", 32'(avm_byteenable), 32'hF);
        checkOutput("const_clken", 32'(avm_clken), 32'd1);
        reset_n = 1'b1;
        tick();

        // Two full words
        cs_base = cs_cnt; done_base = done_cnt;
        applyStimulus(16, 8);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        waitDone("t1_done_timeout", 100);
        repeat (3) tick();
        checkOutput("t1_cs_count", 32'(cs_cnt - cs_base), 32'd2);
        checkOutput("t1_addr0", 32'(cs_addr_q[cs_base]), 32'h10);
        checkOutput("t1_addr1", 32'(cs_addr_q[cs_base + 1]), 32'h11);
        checkOutput("t1_done_count", 32'(done_cnt - done_base), 32'd1);
        checkOutput("t1_left", 32'(exp_q.size()), 32'd0);
        checkOutput("t1_idle", 32'(busy), 32'd0);

        // Zero-length command
        cs_base = cs_cnt; done_base = done_cnt; valid_base = valid_cnt;
        applyStimulus(32, 0);
        waitDone("t2_done_timeout", 10);
        checkOutput("t2_done_latency", 32'((done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2)), 32'd1);
        repeat (3) tick();
        checkOutput("t2_cs_count", 32'(cs_cnt - cs_base), 32'd0);
        checkOutput("t2_valid_count", 32'(valid_cnt - valid_base), 32'd0);
        checkOutput("t2_done_count", 32'(done_cnt - done_base), 32'd1);

        // Partial last word
        cs_base = cs_cnt; done_base = done_cnt;
        applyStimulus(16, 5);
        waitDone("t3_done_timeout", 100);
        repeat (6) tick();
        checkOutput("t3_cs_count", 32'(cs_cnt - cs_base), 32'd2);
        checkOutput("t3_left", 32'(exp_q.size()), 32'd0);
        checkOutput("t3_done_count", 32'(done_cnt - done_base), 32'd1);

        // Address wrap at the memory depth
        cs_base = cs_cnt;
        applyStimulus(DEPTH_WORDS - 1, 8);
        waitDone("t4_done_timeout", 100);
        repeat (2) tick();
        checkOutput("t4_cs_count", 32'(cs_cnt - cs_base), 32'd2);
        checkOutput("t4_addr0", 32'(cs_addr_q[cs_base]), 32'(DEPTH_WORDS - 1));
        checkOutput("t4_addr1", 32'(cs_addr_q[cs_base + 1]), 32'd0);

        // Random backpressure
        cs_base = cs_cnt; done_base = done_cnt;
        rand_mode = 1'b1;
        applyStimulus(256, 64);
        waitDone("t5_done_timeout", 2000);
        rand_mode = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        checkOutput("t5_cs_count", 32'(cs_cnt - cs_base), 32'd16);
        checkOutput("t5_left", 32'(exp_q.size()), 32'd0);
        checkOutput("t5_done_count", 32'(done_cnt - done_base), 32'd1);

        // Abort while waiting for the second word
        cs_base = cs_cnt; done_base = done_cnt;
        applyStimulus(16, 8);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            tick();
            if (cs_cnt - cs_base >= 2) hit = 1'b1;
        end
        checkOutput("t6_second_req", 32'(hit), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_cs", 32'(avm_chipselect), 32'd0);
        checkOutput("t6_left", 32'(exp_q.size()), 32'd4);
        exp_q.delete();
        repeat (3) tick();
        checkOutput("t6_no_done", 32'(done_cnt - done_base), 32'd0);
        applyStimulus(17, 4);
        waitDone("t6_restart_timeout", 100);
        repeat (2) tick();
        checkOutput("t6_restart_left", 32'(exp_q.size()), 32'd0);
        checkOutput("t6_restart_done", 32'(done_cnt - done_base), 32'd1);

        // Reset while emitting
        done_base = done_cnt;
        applyStimulus(16, 8);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (out_valid) hit = 1'b1;
            else tick();
        end
        checkOutput("t7_reached_emit", 32'(hit), 32'd1);
        reset_n = 1'b0;
        tick();
        checkOutput("t7_busy", 32'(busy), 32'd0);
        checkOutput("t7_valid", 32'(out_valid), 32'd0);
        checkOutput("t7_cs", 32'(avm_chipselect), 32'd0);
        checkOutput("t7_addr", 32'(avm_address), 32'd0);
        checkOutput("t7_data", 32'(out_data), 32'd0);
        checkOutput("t7_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        exp_q.delete();
        repeat (3) tick();
        checkOutput("t7_no_done", 32'(done_cnt - done_base), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
